// File: rtl/cache_way_ctrl.sv
// cache_way_ctrl: tag/valid/dirty store and miss FSM for a 4-way set-associative cache.
// Resolves hits in one cycle. On a miss it picks a victim: the lowest invalid way,
// otherwise the pLRU way. It writes back the victim if it is dirty, then refills the line.
// Ports:
//   clk_i, rst_ni       clock, synchronous active-low reset
//   cpu_req_*           CPU request (valid/ready handshake, we, tag, index)
//   cpu_rsp_*           one-cycle completion pulse with hit flag and way
//   plru_way_i          pLRU victim for set plru_index_o
//   plru_valid/index/way_o  one-cycle pLRU update per completed access
//   mem_req_*           write-back / refill request (valid/ready handshake)
//   mem_rsp_valid_i     memory transaction finished
module cache_way_ctrl #(
   parameter int unsigned TAG_W   = 20,
   parameter int unsigned INDEX_W = 6
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               cpu_req_valid_i,
   output logic               cpu_req_ready_o,
   input  logic               cpu_req_we_i,
   input  logic [TAG_W-1:0]   cpu_req_tag_i,
   input  logic [INDEX_W-1:0] cpu_req_index_i,
   output logic               cpu_rsp_valid_o,
   output logic               cpu_rsp_hit_o,
   output logic [1:0]         cpu_rsp_way_o,
   input  logic [1:0]         plru_way_i,
   output logic               plru_valid_o,
   output logic [INDEX_W-1:0] plru_index_o,
   output logic [1:0]         plru_way_o,
   output logic               mem_req_valid_o,
   input  logic               mem_req_ready_i,
   output logic               mem_req_we_o,
   output logic [TAG_W-1:0]   mem_req_tag_o,
   output logic [INDEX_W-1:0] mem_req_index_o,
   input  logic               mem_rsp_valid_i
);

   localparam int unsigned DEPTH = 1 << INDEX_W;

   typedef enum logic [2:0] {
      S_IDLE, S_COMPARE, S_WB, S_WB_WAIT, S_REFILL, S_RF_WAIT
   } state_e;

   state_e                       state_q, state_d;
   logic                         req_we_q, req_we_d;
   logic [TAG_W-1:0]             req_tag_q, req_tag_d;
   logic [INDEX_W-1:0]           req_index_q, req_index_d;
   logic [1:0]                   victim_q, victim_d;
   logic [DEPTH-1:0][3:0]        valid_q, valid_d;
   logic [DEPTH-1:0][3:0]        dirty_q, dirty_d;
   logic [TAG_W-1:0]             tag_mem_q [DEPTH][4];

   logic [3:0] set_valid, set_dirty;
   logic       hit, has_invalid, tag_we;
   logic [1:0] hit_way, invalid_way, victim_sel;

   assign set_valid = valid_q[req_index_q];
   assign set_dirty = dirty_q[req_index_q];

   // Lowest-index match / lowest-index invalid way
   always_comb begin
      hit         = 1'b0;
      hit_way     = 2'd0;
      has_invalid = 1'b0;
      invalid_way = 2'd0;
      for (int unsigned w = 0; w < 4; w++) begin
         if (!hit && set_valid[w] && (tag_mem_q[req_index_q][w] == req_tag_q)) begin
            hit     = 1'b1;
            hit_way = w[1:0];
         end
         if (!has_invalid && !set_valid[w]) begin
            has_invalid = 1'b1;
            invalid_way = w[1:0];
         end
      end
      victim_sel = has_invalid ? invalid_way : plru_way_i;
   end

   always_comb begin
      state_d     = state_q;
      req_we_d    = req_we_q;
      req_tag_d   = req_tag_q;
      req_index_d = req_index_q;
      victim_d    = victim_q;
      valid_d     = valid_q;
      dirty_d     = dirty_q;
      tag_we      = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (cpu_req_valid_i) begin
               req_we_d    = cpu_req_we_i;
               req_tag_d   = cpu_req_tag_i;
               req_index_d = cpu_req_index_i;
               state_d     = S_COMPARE;
            end
         end
         S_COMPARE: begin
            if (hit) begin
               if (req_we_q) dirty_d[req_index_q][hit_way] = 1'b1;
               state_d = S_IDLE;
            end else begin
               victim_d = victim_sel;
               state_d  = (set_valid[victim_sel] && set_dirty[victim_sel]) ? S_WB : S_REFILL;
            end
         end
         S_WB: begin
            if (mem_req_ready_i) state_d = S_WB_WAIT;
         end
         S_WB_WAIT: begin
            if (mem_rsp_valid_i) begin
               dirty_d[req_index_q][victim_q] = 1'b0;
               state_d = S_REFILL;
            end
         end
         S_REFILL: begin
            if (mem_req_ready_i) state_d = S_RF_WAIT;
         end
         S_RF_WAIT: begin
            if (mem_rsp_valid_i) begin
               tag_we                         = 1'b1;
               valid_d[req_index_q][victim_q] = 1'b1;
               dirty_d[req_index_q][victim_q] = req_we_q;
               state_d                        = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q     <= S_IDLE;
         req_we_q    <= 1'b0;
         req_tag_q   <= '0;
         req_index_q <= '0;
         victim_q    <= 2'd0;
         valid_q     <= '0;
         dirty_q     <= '0;
      end else begin
         state_q     <= state_d;
         req_we_q    <= req_we_d;
         req_tag_q   <= req_tag_d;
         req_index_q <= req_index_d;
         victim_q    <= victim_d;
         valid_q     <= valid_d;
         dirty_q     <= dirty_d;
      end
   end

   // Tag storage needs no reset: entries are qualified by valid_q
   always_ff @(posedge clk_i) begin
      if (tag_we) tag_mem_q[req_index_q][victim_q] <= req_tag_q;
   end

   logic compare_hit, refill_done;
   // Completion pulses are suppressed in the reset cycle so an abandoned access never reports
   assign compare_hit = rst_ni && (state_q == S_COMPARE) && hit;
   assign refill_done = rst_ni && (state_q == S_RF_WAIT) && mem_rsp_valid_i;

   always_comb begin
      cpu_req_ready_o = (state_q == S_IDLE);
      cpu_rsp_valid_o = compare_hit || refill_done;
      cpu_rsp_hit_o   = compare_hit;
      cpu_rsp_way_o   = compare_hit ? hit_way : (refill_done ? victim_q : 2'd0);
      plru_valid_o    = cpu_rsp_valid_o;
      plru_index_o    = req_index_q;
      plru_way_o      = cpu_rsp_way_o;
      mem_req_valid_o = (state_q == S_WB) || (state_q == S_REFILL);
      mem_req_we_o    = (state_q == S_WB);
      mem_req_tag_o   = '0;
      if (state_q == S_WB)          mem_req_tag_o = tag_mem_q[req_index_q][victim_q];
      else if (state_q == S_REFILL) mem_req_tag_o = req_tag_q;
      mem_req_index_o = mem_req_valid_o ? req_index_q : '0;
   end

endmodule

// File: tb/tb_cache_way_ctrl.sv
module tb_cache_way_ctrl;

   localparam int unsigned TAG_W   = 20;
   localparam int unsigned INDEX_W = 6;
   localparam int unsigned DEPTH   = 64;

   logic               clk_i = 1'b0;
   logic               rst_ni;
   logic               cpu_req_valid_i, cpu_req_ready_o, cpu_req_we_i;
   logic [TAG_W-1:0]   cpu_req_tag_i;
   logic [INDEX_W-1:0] cpu_req_index_i;
   logic               cpu_rsp_valid_o, cpu_rsp_hit_o;
   logic [1:0]         cpu_rsp_way_o, plru_way_i, plru_way_o;
   logic               plru_valid_o;
   logic [INDEX_W-1:0] plru_index_o, mem_req_index_o;
   logic               mem_req_valid_o, mem_req_ready_i, mem_req_we_o, mem_rsp_valid_i;
   logic [TAG_W-1:0]   mem_req_tag_o;

   cache_way_ctrl #(.TAG_W(TAG_W), .INDEX_W(INDEX_W)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .cpu_req_valid_i(cpu_req_valid_i), .cpu_req_ready_o(cpu_req_ready_o),
      .cpu_req_we_i(cpu_req_we_i), .cpu_req_tag_i(cpu_req_tag_i),
      .cpu_req_index_i(cpu_req_index_i),
      .cpu_rsp_valid_o(cpu_rsp_valid_o), .cpu_rsp_hit_o(cpu_rsp_hit_o),
      .cpu_rsp_way_o(cpu_rsp_way_o),
      .plru_way_i(plru_way_i), .plru_valid_o(plru_valid_o),
      .plru_index_o(plru_index_o), .plru_way_o(plru_way_o),
      .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
      .mem_req_we_o(mem_req_we_o), .mem_req_tag_o(mem_req_tag_o),
      .mem_req_index_o(mem_req_index_o), .mem_rsp_valid_i(mem_rsp_valid_i)
   );

   always #5 clk_i = ~clk_i;

   int checks   = 0;
   int failures = 0;

   // Reference cache state
   bit               m_valid [DEPTH][4];
   bit               m_dirty [DEPTH][4];
   logic [TAG_W-1:0] m_tag   [DEPTH][4];
   int unsigned      stall_n = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int s = 0; s < DEPTH; s++)
         for (int w = 0; w < 4; w++) begin
            m_valid[s][w] = 1'b0;
            m_dirty[s][w] = 1'b0;
         end
   endtask

   // One memory transaction: request phase (checked stable every cycle) then response wait.
   task automatic mem_phase(input bit we, input logic [TAG_W-1:0] tag,
                            input logic [INDEX_W-1:0] idx, input bit refill,
                            input logic [1:0] way, input bit abort);
      bit acc = 1'b0;
      int unsigned d;
      for (int unsigned n = 0; n < stall_n + 16 && !acc; n++) begin
         @(negedge clk_i);
         mem_req_ready_i = (n >= stall_n) && ((n >= stall_n + 8) || ($urandom_range(0, 1) == 1));
         mem_rsp_valid_i = ($urandom_range(0, 3) == 0);
         plru_way_i      = 2'($urandom_range(0, 3));
         #1;
         check("mreq_valid", 32'(mem_req_valid_o), 32'd1);
         check("mreq_we",    32'(mem_req_we_o),    32'(we));
         check("mreq_tag",   32'(mem_req_tag_o),   32'(tag));
         check("mreq_index", 32'(mem_req_index_o), 32'(idx));
         check("rsp_quiet",  32'(cpu_rsp_valid_o), 32'd0);
         check("plru_quiet", 32'(plru_valid_o),    32'd0);
         acc = mem_req_ready_i;
      end
      if (!acc) check("mreq_accept", 32'd0, 32'd1);
      d = $urandom_range(0, 3);
      for (int unsigned k = 0; k <= d; k++) begin
         @(negedge clk_i);
         mem_req_ready_i = 1'($urandom_range(0, 1));
         mem_rsp_valid_i = (k == d);
         if (abort && k == d) rst_ni = 1'b0;
         #1;
         check("mreq_idle_wait", 32'(mem_req_valid_o), 32'd0);
         if (k == d && refill && !abort) begin
            check("rsp_valid", 32'(cpu_rsp_valid_o), 32'd1);
            check("rsp_hit",   32'(cpu_rsp_hit_o),   32'd0);
            check("rsp_way",   32'(cpu_rsp_way_o),   32'(way));
            check("plru_valid", 32'(plru_valid_o),   32'd1);
            check("plru_index", 32'(plru_index_o),   32'(idx));
            check("plru_way",   32'(plru_way_o),     32'(way));
         end else begin
            check("rsp_none",  32'(cpu_rsp_valid_o), 32'd0);
            check("plru_none", 32'(plru_valid_o),    32'd0);
         end
      end
      if (abort) begin
         @(negedge clk_i);
         rst_ni          = 1'b1;
         mem_rsp_valid_i = 1'b0;
         #1;
         check("abort_ready", 32'(cpu_req_ready_o), 32'd1);
         check("abort_mreq",  32'(mem_req_valid_o), 32'd0);
         check("abort_rsp",   32'(cpu_rsp_valid_o), 32'd0);
         model_reset();
      end
   endtask

   task automatic do_access(input logic [INDEX_W-1:0] idx, input logic [TAG_W-1:0] tag,
                            input bit we, input logic [1:0] pl, input bit abort);
      bit         hit = 1'b0;
      logic [1:0] way = 2'd0;
      // Present request in IDLE with stray memory response noise
      @(negedge clk_i);
      cpu_req_valid_i = 1'b1;
      cpu_req_we_i    = we;
      cpu_req_tag_i   = tag;
      cpu_req_index_i = idx;
      plru_way_i      = pl;
      mem_rsp_valid_i = 1'($urandom_range(0, 1));
      mem_req_ready_i = 1'($urandom_range(0, 1));
      #1;
      check("idle_ready", 32'(cpu_req_ready_o), 32'd1);
      check("idle_mreq",  32'(mem_req_valid_o), 32'd0);
      // Compare cycle
      @(negedge clk_i);
      cpu_req_valid_i = 1'b0;
      cpu_req_tag_i   = TAG_W'($urandom);
      cpu_req_index_i = INDEX_W'($urandom);
      mem_rsp_valid_i = 1'($urandom_range(0, 1));
      #1;
      check("cmp_ready", 32'(cpu_req_ready_o), 32'd0);
      check("cmp_mreq",  32'(mem_req_valid_o), 32'd0);
      for (int w = 0; w < 4; w++)
         if (!hit && m_valid[idx][w] && m_tag[idx][w] == tag) begin
            hit = 1'b1;
            way = 2'(w);
         end
      if (hit) begin
         check("hit_rsp_valid", 32'(cpu_rsp_valid_o), 32'd1);
         check("hit_rsp_hit",   32'(cpu_rsp_hit_o),   32'd1);
         check("hit_rsp_way",   32'(cpu_rsp_way_o),   32'(way));
         check("hit_plru_valid", 32'(plru_valid_o),   32'd1);
         check("hit_plru_index", 32'(plru_index_o),   32'(idx));
         check("hit_plru_way",   32'(plru_way_o),     32'(way));
         if (we) m_dirty[idx][way] = 1'b1;
      end else begin
         bit found = 1'b0;
         for (int w = 0; w < 4; w++)
            if (!found && !m_valid[idx][w]) begin
               found = 1'b1;
               way   = 2'(w);
            end
         if (!found) way = pl;
         check("miss_rsp",  32'(cpu_rsp_valid_o), 32'd0);
         check("miss_plru", 32'(plru_valid_o),    32'd0);
         if (m_valid[idx][way] && m_dirty[idx][way]) begin
            mem_phase(1'b1, m_tag[idx][way], idx, 1'b0, way, 1'b0);
            m_dirty[idx][way] = 1'b0;
         end
         mem_phase(1'b0, tag, idx, 1'b1, way, abort);
         if (!abort) begin
            m_tag[idx][way]   = tag;
            m_valid[idx][way] = 1'b1;
            m_dirty[idx][way] = we;
         end
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_ni          = 1'b0;
      cpu_req_valid_i = 1'b0;
      cpu_req_we_i    = 1'b0;
      cpu_req_tag_i   = '0;
      cpu_req_index_i = '0;
      plru_way_i      = 2'd0;
      mem_req_ready_i = 1'b0;
      mem_rsp_valid_i = 1'b0;
      model_reset();
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      rst_ni = 1'b1;
      #1;
      check("rst_ready", 32'(cpu_req_ready_o), 32'd1);
      check("rst_rsp",   32'(cpu_rsp_valid_o), 32'd0);
      check("rst_plru",  32'(plru_valid_o),    32'd0);
      check("rst_mreq",  32'(mem_req_valid_o), 32'd0);
      check("rst_mwe",   32'(mem_req_we_o),    32'd0);

      // Cold miss, then store hit marking way 0 dirty
      do_access(6'd3, 20'h000AB, 1'b0, 2'd0, 1'b0);
      do_access(6'd3, 20'h000AB, 1'b1, 2'd0, 1'b0);
      // Fill the set, then evict dirty way 0 with long request stalls
      do_access(6'd3, 20'h00101, 1'b0, 2'd0, 1'b0);
      do_access(6'd3, 20'h00102, 1'b0, 2'd0, 1'b0);
      do_access(6'd3, 20'h00103, 1'b0, 2'd0, 1'b0);
      stall_n = 5;
      do_access(6'd3, 20'h000FF, 1'b0, 2'd0, 1'b0);
      stall_n = 0;
      // Reset during refill wait, then the same access must miss into way 0
      do_access(6'd5, 20'h00055, 1'b0, 2'd2, 1'b1);
      do_access(6'd5, 20'h00055, 1'b0, 2'd2, 1'b0);
      do_access(6'd5, 20'h00055, 1'b0, 2'd2, 1'b0);

      for (int i = 0; i < 300; i++) begin
         do_access(INDEX_W'($urandom_range(0, 3) * 2 + 3),
                   TAG_W'($urandom_range(0, 7)),
                   1'($urandom_range(0, 1)),
                   2'($urandom_range(0, 3)),
                   ($urandom_range(0, 39) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
